bram_bus_adapter: RTL
=====================

# bram_bus_adapter

Front-end for one port of the dual-port block RAM. Converts the CPU-style access/ack memory bus (byte addressed, 8- or 16-bit transfers) into the RAM's word-addressed, byte-enabled port protocol. Unaligned 16-bit transfers are split into two RAM cycles. Read data is realigned so the bus master always sees little-endian data in the low lanes. Sits directly upstream of the RAM port and consumes its registered read data.

## Interface
- words, 8, RAM depth in 16-bit words (power of two, ≥2); localparam addr_bits = $clog2(words)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cs  in  1  chip select; access is ignored while low
- access  in  1  request; held stable by master until ack
- wr_en  in  1  1 = write, 0 = read
- width16  in  1  1 = 16-bit transfer, 0 = 8-bit
- addr  in  addr_bits+1  byte address
- wdata  in  16  write data; byte transfers use wdata[7:0]
- rdata  out  16  read data, valid only while ack=1; byte reads zero-extend
- ack  out  1  one-cycle completion pulse
- ram_addr  out  addr_bits  RAM word address
- ram_wr_en  out  1  RAM write strobe
- ram_be  out  2  RAM byte enables
- ram_wdata  out  16  RAM write data
- ram_q  in  16  RAM read data, valid the cycle after ram_addr is presented

## Operation
- Request latched on the rising edge where state=IDLE, access=1, cs=1. The latched copy drives all RAM outputs. There is no combinational path from bus inputs to RAM outputs.
- Word index W = addr[addr_bits:1]. Split = width16 & addr[0].
- Aligned word: ram_addr=W, be=11, ram_wdata=wdata, rdata=ram_q.
- Even byte: be=01, ram_wdata={wdata[7:0],wdata[7:0]}, rdata={8'h00,ram_q[7:0]}.
- Odd byte: be=10, same ram_wdata, rdata={8'h00,ram_q[15:8]}.
- Split word:
  - First RAM cycle: ram_addr=W, be=10.
  - Second RAM cycle: ram_addr=W+1 mod words (wraps from words-1 to 0), be=01.
  - ram_wdata={wdata[7:0],wdata[15:8]} in both cycles.
  - rdata={second q[7:0], first q[15:8]}.
- State machine:
  - IDLE: on a latched request, go to ISSUE1.
  - ISSUE1: if split, go to ISSUE2; otherwise go to WAIT for a read or DONE for a write.
  - ISSUE2: capture the first ram_q[15:8] if reading; go to WAIT for a read or DONE for a write.
  - WAIT: capture the final data into rdata; go to DONE.
  - DONE: ack=1; go to IDLE.
- RAM outputs in each state:
  - ram_wr_en = latched wr_en during ISSUE1/ISSUE2, otherwise 0.
  - ram_be = 00 outside ISSUE1/ISSUE2.
  - ram_addr holds its last value outside ISSUE1/ISSUE2.
- access falling or cs changing mid-transaction: ignored; the transaction completes and ack still pulses.
- access still high in the cycle after DONE is a new request. The master must deassert access after sampling ack.
- Reset values: state IDLE; ack 0, rdata 0, ram_addr 0, ram_wr_en 0, ram_be 00, ram_wdata 0.
- Reset mid-split-write may leave the first byte written. This is permitted and needs no rollback.

## Timing
Cycle 0 is the first cycle with access=1 while IDLE.
- Aligned/byte write: RAM write in cycle 1; ack in cycle 2.
- Aligned/byte read: address in cycle 1, q in cycle 2; ack and rdata in cycle 3.
- Split write: RAM writes in cycles 1 and 2; ack in cycle 3.
- Split read: addresses in cycles 1 and 2, first byte captured at the end of cycle 2; ack in cycle 4.
- Back-to-back throughput: one transaction per latency+1 cycles, since IDLE occupies one cycle between transactions.

## Structure
- Package bram_bus_pkg holds:
  - typedef enum logic [2:0] bram_bus_state_t {IDLE, ISSUE1, ISSUE2, WAIT, DONE};
  - localparam encodings for BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11.
- One natural sub-module: bram_lane_steer, purely combinational. From the latched addr[0], width16, phase and wdata, it computes ram_be and ram_wdata. It also computes the read-lane select used at capture.
- FSM, request latch and rdata register stay in bram_bus_adapter.

## Test plan
- Reset: assert reset_n=0 mid-ISSUE1 → all outputs return to their reset values immediately; next access behaves normally.
- Aligned word: write 16'hBEEF to addr 4 → single ram write, W=2, be=11, ack in cycle 2. Read addr 4 → rdata=16'hBEEF with ack in cycle 3.
- Byte lanes: write 8'h5A to addr 3, then read addr 3 (byte) → rdata=16'h005A. Read addr 2 (word) → rdata[15:8]=8'h5A with the low byte unchanged.
- Split wrap (words=8): write 16'h1234 to addr 15 → cycle 1: W=7, be=10, ram_wdata[15:8]=8'h34; cycle 2: W=0, be=01, ram_wdata[7:0]=8'h12; ack in cycle 3. Read addr 15 → rdata=16'h1234 with ack in cycle 4.
- cs low: access=1, cs=0 for 10 cycles → no ack, ram_wr_en and ram_be stay 0.
- Held access: keep access high after ack → a second identical transaction starts in the cycle after DONE and produces a second ack.

Source files
------------

// File: rtl/bram_bus_adapter_pkg.sv
// bram_bus_pkg: shared state, byte-enable and read-lane encodings for the BRAM bus adapter.
package bram_bus_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE1, ISSUE2, WAIT, DONE} bram_bus_state_t;
    typedef enum logic [1:0] {SEL_WORD, SEL_LO, SEL_HI, SEL_SPLIT} bram_rd_sel_t;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;
endpackage

// File: rtl/bram_bus_adapter_if.sv
// bram_bus_adapter_if: CPU access/ack bus plus the word-addressed RAM port it is converted to.
interface bram_bus_adapter_if #(parameter int words = 8);
    localparam int addr_bits = $clog2(words);
    logic                 cs;
    logic                 access;
    logic                 wr_en;
    logic                 width16;
    logic [addr_bits:0]   addr;
    logic [15:0]          wdata;
    logic [15:0]          rdata;
    logic                 ack;
    logic [addr_bits-1:0] ram_addr;
    logic                 ram_wr_en;
    logic [1:0]           ram_be;
    logic [15:0]          ram_wdata;
    logic [15:0]          ram_q;
    modport master (output cs, access, wr_en, width16, addr, wdata, input rdata, ack);
    modport ram    (input ram_addr, ram_wr_en, ram_be, ram_wdata, output ram_q);
    modport slave  (input cs, access, wr_en, width16, addr, wdata, ram_q,
                    output rdata, ack, ram_addr, ram_wr_en, ram_be, ram_wdata);
endinterface

// File: rtl/bram_bus_adapter_lane_steer.sv
// bram_lane_steer: byte enables, write-lane replication/swap and read-lane select for one RAM cycle.
module bram_lane_steer
    import bram_bus_pkg::*;
(
    input  logic         i_a0,
    input  logic         i_w16,
    input  logic         i_ph,
    input  logic [15:0]  i_wdata,
    output logic [1:0]   o_be,
    output logic [15:0]  o_wdata,
    output bram_rd_sel_t o_sel
);
    // Split words write the low bus byte into the high lane first, then the high byte into the next word.
    assign o_be    = i_w16 ? (i_a0 ? (i_ph ? BE_LO : BE_HI) : BE_WORD) : (i_a0 ? BE_HI : BE_LO);
    assign o_wdata = i_w16 ? (i_a0 ? {i_wdata[7:0], i_wdata[15:8]} : i_wdata) : {2{i_wdata[7:0]}};
    assign o_sel   = i_w16 ? (i_a0 ? SEL_SPLIT : SEL_WORD) : (i_a0 ? SEL_HI : SEL_LO);
endmodule

// File: rtl/bram_bus_adapter.sv
// bram_bus_adapter: byte-addressed 8/16-bit access/ack bus to word-addressed byte-enabled RAM port.
module bram_bus_adapter
    import bram_bus_pkg::*;
#(
    parameter int words = 8
) (
    input logic               clk,
    input logic               reset_n,
    bram_bus_adapter_if.slave bus
);
    localparam int addr_bits = $clog2(words);

    bram_bus_state_t    r_state;
    logic               r_wr;
    logic               r_w16;
    logic               r_ph;
    logic [addr_bits:0] r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_rdata;
    logic [7:0]         r_lo;
    logic [1:0]         w_be;
    logic [15:0]        w_wdata;
    logic [15:0]        w_rd;
    bram_rd_sel_t       w_sel;
    logic               w_issue;
    logic               w_split;

    bram_lane_steer u_steer (
        .i_a0    (r_addr[0]),
        .i_w16   (r_w16),
        .i_ph    (r_ph),
        .i_wdata (r_wdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_sel   (w_sel)
    );

    assign w_issue = (r_state == ISSUE1) || (r_state == ISSUE2);
    assign w_split = r_w16 & r_addr[0];
    assign w_rd    = (w_sel == SEL_WORD) ? bus.ram_q :
                     (w_sel == SEL_LO)   ? {8'h00, bus.ram_q[7:0]} :
                     (w_sel == SEL_HI)   ? {8'h00, bus.ram_q[15:8]} : {bus.ram_q[7:0], r_lo};

    // RAM outputs come only from latched state; r_ph keeps ram_addr on W+1 after a split.
    assign bus.ram_addr  = r_addr[addr_bits:1] + addr_bits'(r_ph);
    assign bus.ram_wr_en = w_issue & r_wr;
    assign bus.ram_be    = w_issue ? w_be : 2'b00;
    assign bus.ram_wdata = w_wdata;
    assign bus.rdata     = r_rdata;
    assign bus.ack       = (r_state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_w16   <= 1'b0;
            r_ph    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_lo    <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (bus.access && bus.cs) begin
                    r_wr    <= bus.wr_en;
                    r_w16   <= bus.width16;
                    r_addr  <= bus.addr;
                    r_wdata <= bus.wdata;
                    r_ph    <= 1'b0;
                    r_state <= ISSUE1;
                end
                ISSUE1: begin
                    r_ph    <= w_split;
                    r_state <= w_split ? ISSUE2 : (r_wr ? DONE : WAIT);
                end
                ISSUE2: begin
                    if (!r_wr) r_lo <= bus.ram_q[15:8];
                    r_state <= r_wr ? DONE : WAIT;
                end
                WAIT: begin
                    r_rdata <= w_rd;
                    r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
